uart_tx_buffered: RTL and testbench

//   Buffered 8N1 UART transmitter driving the board UART pin uo_out[0].
//   The CPU-side peripheral register writes bytes into an internal FIFO.
//   The transmitter serialises them back-to-back, LSB first, at CLK_DIV clocks per bit.

---
 rtl/uart_tx_buffered.sv | 132 +++++++++++++
 tb/tb_uart_tx_buffered.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: a circular byte FIFO feeds a START/DATA/STOP
// serialiser that sends frames back-to-back, LSB first, CLK_DIV clocks per bit.
module uart_tx_buffered #(
  parameter int CLK_DIV    = 217,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLK_DIV + 1);
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLK_DIV - 1);
  localparam logic [PW:0]   LEVEL_FULL  = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [7:0]      shift;
  logic [2:0]      bitcnt;
  logic [BW-1:0]   baud_cnt;
  logic            baud_done;
  logic            push;
  logic            pop;

  // Handshake: a byte is taken when tx_valid && tx_ready at a rising clk edge;
  // tx_data matters only on that edge. tx_ready depends on registers only, so a
  // pop in the same cycle as a full FIFO never lets a write through.
  assign tx_ready  = (level != LEVEL_FULL);
  assign push      = tx_valid && tx_ready;
  assign baud_done = (baud_cnt == '0);
  assign pop       = (level != '0) && ((state == IDLE) || ((state == STOP) && baud_done));
  assign busy      = (state != IDLE) || (level != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      txd      <= 1'b1;
      shift    <= '0;
      bitcnt   <= '0;
      baud_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (pop) begin
            shift    <= mem[rd_ptr];
            txd      <= 1'b0;
            baud_cnt <= BAUD_RELOAD;
            state    <= START;
          end
        end
        START: begin
          if (baud_done) begin
            txd      <= shift[0];
            shift    <= {1'b0, shift[7:1]};
            bitcnt   <= '0;
            baud_cnt <= BAUD_RELOAD;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt <= BAUD_RELOAD;
            if (bitcnt == 3'd7) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              txd    <= shift[0];
              shift  <= {1'b0, shift[7:1]};
              bitcnt <= bitcnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        STOP: begin
          // Chaining straight into the next start bit keeps frames gap-free.
          if (baud_done) begin
            if (pop) begin
              shift    <= mem[rd_ptr];
              txd      <= 1'b0;
              baud_cnt <= BAUD_RELOAD;
              state    <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        default: begin
          txd   <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: table-driven waveform checks plus
// hand-written sequences for back-to-back, fill, push/pop and reset cases.
module tb_uart_tx_buffered;

  localparam int DIV   = 217;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  typedef struct {
    int            off;
    logic          txd;
    logic          busy;
    logic [LW-1:0] lvl;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  logic [7:0]    tx_data, tx_data1;
  logic          tx_valid, tx_valid1;
  logic          tx_ready, tx_ready1;
  logic          txd, txd1;
  logic          busy, busy1;
  logic [LW-1:0] level, level1;

  uart_tx_buffered #(.CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .txd(txd), .busy(busy), .level(level)
  );

  uart_tx_buffered #(.CLK_DIV(1), .FIFO_DEPTH(DEPTH)) dut1 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data1), .tx_valid(tx_valid1),
    .tx_ready(tx_ready1), .txd(txd1), .busy(busy1), .level(level1)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         start_q[$];
  bit         mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int k;
    k = 0;
    while (got_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk("decoded_count", got_q.size(), n);
  endtask

  task automatic drain_compare();
    logic [7:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() > 0) chk("decoded_byte", got_q.pop_front(), e);
      else                  chk("decoded_missing", 32'hffff_ffff, e);
    end
    chk("decoded_extra", got_q.size(), 0);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < budget) begin
      tick();
      k++;
    end
    chk("idle_reached", busy, 0);
  endtask

  // UART line monitor on the CLK_DIV=217 instance, sampling mid-bit.
  initial begin : monitor
    logic [7:0] b;
    int st;
    forever begin
      @(posedge clk);
      #2;
      if (mon_en && txd === 1'b0) begin
        st = cyc;
        repeat (DIV / 2) @(posedge clk);
        #2;
        for (int j = 0; j < 8; j++) begin
          repeat (DIV) @(posedge clk);
          #2;
          b[j] = txd;
        end
        repeat (DIV) @(posedge clk);
        #2;
        chk("stop_bit", txd, 1);
        got_q.push_back(b);
        start_q.push_back(st);
      end
    end
  end

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  vec_t v1[22];
  vec_t v6[12];
  logic [7:0] str[3];
  int t;
  int acc;
  int bad;

  initial begin
    // Single 0x4F frame at CLK_DIV=217: bits 1,1,1,1,0,0,1,0 after start.
    v1[0]  = '{0,    1'b1, 1'b1, 4'd1};
    v1[1]  = '{1,    1'b0, 1'b1, 4'd0};
    v1[2]  = '{217,  1'b0, 1'b1, 4'd0};
    v1[3]  = '{218,  1'b1, 1'b1, 4'd0};
    v1[4]  = '{434,  1'b1, 1'b1, 4'd0};
    v1[5]  = '{435,  1'b1, 1'b1, 4'd0};
    v1[6]  = '{651,  1'b1, 1'b1, 4'd0};
    v1[7]  = '{652,  1'b1, 1'b1, 4'd0};
    v1[8]  = '{868,  1'b1, 1'b1, 4'd0};
    v1[9]  = '{869,  1'b1, 1'b1, 4'd0};
    v1[10] = '{1085, 1'b1, 1'b1, 4'd0};
    v1[11] = '{1086, 1'b0, 1'b1, 4'd0};
    v1[12] = '{1302, 1'b0, 1'b1, 4'd0};
    v1[13] = '{1303, 1'b0, 1'b1, 4'd0};
    v1[14] = '{1519, 1'b0, 1'b1, 4'd0};
    v1[15] = '{1520, 1'b1, 1'b1, 4'd0};
    v1[16] = '{1736, 1'b1, 1'b1, 4'd0};
    v1[17] = '{1737, 1'b0, 1'b1, 4'd0};
    v1[18] = '{1953, 1'b0, 1'b1, 4'd0};
    v1[19] = '{1954, 1'b1, 1'b1, 4'd0};
    v1[20] = '{2170, 1'b1, 1'b1, 4'd0};
    v1[21] = '{2171, 1'b1, 1'b0, 4'd0};

    // 0xA5 at CLK_DIV=1: 0,1,0,1,0,0,1,0,1,1 on consecutive cycles.
    v6[0]  = '{0,  1'b1, 1'b1, 4'd1};
    v6[1]  = '{1,  1'b0, 1'b1, 4'd0};
    v6[2]  = '{2,  1'b1, 1'b1, 4'd0};
    v6[3]  = '{3,  1'b0, 1'b1, 4'd0};
    v6[4]  = '{4,  1'b1, 1'b1, 4'd0};
    v6[5]  = '{5,  1'b0, 1'b1, 4'd0};
    v6[6]  = '{6,  1'b0, 1'b1, 4'd0};
    v6[7]  = '{7,  1'b1, 1'b1, 4'd0};
    v6[8]  = '{8,  1'b0, 1'b1, 4'd0};
    v6[9]  = '{9,  1'b1, 1'b1, 4'd0};
    v6[10] = '{10, 1'b1, 1'b1, 4'd0};
    v6[11] = '{11, 1'b1, 1'b0, 4'd0};

    str[0] = 8'h4F;
    str[1] = 8'h4B;
    str[2] = 8'h0A;

    tx_data = 8'h00; tx_valid = 1'b0;
    tx_data1 = 8'h00; tx_valid1 = 1'b0;

    // ---- reset state ----
    rst_n = 1'b0;
    repeat (3) tick();
    chk("reset_txd", txd, 1);
    chk("reset_busy", busy, 0);
    chk("reset_level", level, 0);
    chk("reset_ready", tx_ready, 1);
    chk("reset_txd_div1", txd1, 1);
    rst_n = 1'b1;
    tick();

    // ---- single byte 0x4F, table-driven waveform ----
    mon_en = 1'b1;
    exp_q.push_back(8'h4F);
    tx_data = 8'h4F; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0; tx_data = 8'h00;
    t = 0;
    for (int i = 0; i < 22; i++) begin
      while (t < v1[i].off) begin
        tick();
        t++;
      end
      chk($sformatf("single_txd@%0d", v1[i].off), txd, v1[i].txd);
      chk($sformatf("single_busy@%0d", v1[i].off), busy, v1[i].busy);
      chk($sformatf("single_level@%0d", v1[i].off), level, v1[i].lvl);
    end
    wait_bytes(1, 400);
    drain_compare();
    start_q.delete();

    // ---- "OK\n" on consecutive cycles, back-to-back frames ----
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(str[i]);
      tx_data = str[i]; tx_valid = 1'b1;
      tick();
    end
    tx_valid = 1'b0;
    wait_bytes(3, 3 * 10 * DIV + 400);
    if (start_q.size() >= 3) begin
      chk("gap_0_1", start_q[1] - start_q[0], 10 * DIV);
      chk("gap_1_2", start_q[2] - start_q[1], 10 * DIV);
    end
    drain_compare();
    start_q.delete();
    wait_idle(400);

    // ---- fill: push every cycle from idle ----
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      tx_data = 8'hC0 + 8'(i); tx_valid = 1'b1;
      if (tx_ready) acc++;
      if (i < 9) exp_q.push_back(8'hC0 + 8'(i));
      tick();
    end
    tx_valid = 1'b0;
    chk("fill_accepted", acc, 9);
    chk("fill_level", level, 8);
    chk("fill_ready", tx_ready, 0);
    wait_bytes(9, 9 * 10 * DIV + 400);
    drain_compare();
    start_q.delete();
    wait_idle(400);

    // ---- push on the same edge STOP->START pops ----
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hE1);
    exp_q.push_back(8'h96);
    tx_data = 8'h3C; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    t = 0;
    while (t < 100) begin tick(); t++; end
    tx_data = 8'hE1; tx_valid = 1'b1;
    tick(); t++;
    tx_valid = 1'b0;
    while (t < 10 * DIV) begin tick(); t++; end
    chk("pp_level_before", level, 1);
    chk("pp_txd_stop", txd, 1);
    tx_data = 8'h96; tx_valid = 1'b1;
    tick(); t++;
    tx_valid = 1'b0;
    chk("pp_level_after", level, 1);
    chk("pp_txd_start", txd, 0);
    wait_bytes(3, 3 * 10 * DIV + 400);
    drain_compare();
    start_q.delete();
    wait_idle(400);

    // ---- reset during DATA bit 3 with bytes queued ----
    mon_en = 1'b0;
    tx_data = 8'h00; tx_valid = 1'b1; tick();
    tx_data = 8'h11; tick();
    tx_data = 8'h22; tick();
    tx_data = 8'h33; tick();
    tx_valid = 1'b0;
    t = 3;
    while (t < 1 + 4 * DIV + 100) begin tick(); t++; end
    chk("pre_reset_txd", txd, 0);
    chk("pre_reset_level", level, 3);
    rst_n = 1'b0;
    #1;
    chk("async_reset_txd", txd, 1);
    chk("async_reset_level", level, 0);
    chk("async_reset_busy", busy, 0);
    chk("async_reset_ready", tx_ready, 1);
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 2500; k++) begin
      tick();
      if (txd !== 1'b1 || busy !== 1'b0 || level !== '0) bad++;
    end
    chk("post_reset_quiet", bad, 0);
    mon_en = 1'b1;
    exp_q.push_back(8'h5A);
    tx_data = 8'h5A; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    wait_bytes(1, 10 * DIV + 400);
    drain_compare();
    start_q.delete();
    wait_idle(400);

    // ---- CLK_DIV=1, push 0xA5 ----
    tx_data1 = 8'hA5; tx_valid1 = 1'b1;
    tick();
    tx_valid1 = 1'b0;
    t = 0;
    for (int i = 0; i < 12; i++) begin
      while (t < v6[i].off) begin
        tick();
        t++;
      end
      chk($sformatf("div1_txd@%0d", v6[i].off), txd1, v6[i].txd);
      chk($sformatf("div1_busy@%0d", v6[i].off), busy1, v6[i].busy);
      chk($sformatf("div1_level@%0d", v6[i].off), level1, v6[i].lvl);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
